// File: rtl/inst_fetch_seq.sv
// Read-side sequencer for a synchronous instruction ROM with valid/ready handoff to the decoder.
// Optional HALT detection of an all-ones ROM word is enabled by defining INST_FETCH_HALT_DETECT_EN.
module inst_fetch_seq #(
  parameter int width    = 9,
  parameter int depth    = 32,
  parameter int addrBits = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [addrBits-1:0] ROM_ADDRESS,
  input  logic [0:width-1]    ROM_DATAIN,
  output logic [width-1:0]    INST,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                jump_en,
  input  logic [addrBits-1:0] jump_addr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAP,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [addrBits-1:0] LAST_PC   = addrBits'(depth - 1);
  localparam logic [addrBits:0]   DEPTH_EXT = (addrBits + 1)'(depth);

  state_t              state_q, state_d;
  logic [addrBits-1:0] pc_q, pc_d;
  logic [width-1:0]    inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                jump_in_range;

  // Zero-extend so a target equal to 2^addrBits-1 still compares correctly when depth is a power of two.
  assign jump_in_range = ({1'b0, jump_addr} < DEPTH_EXT);

  always_comb begin
    // NOTE: every _d takes its held value first so no path through the case can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ADDR;
          pc_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_ADDR: state_d = S_CAP;

      S_CAP: begin
`ifdef INST_FETCH_HALT_DETECT_EN
        if (&ROM_DATAIN) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          inst_d  = ROM_DATAIN;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
`else
        // Positional copy: ROM_DATAIN[0] lands on INST[width-1].
        inst_d  = ROM_DATAIN;
        valid_d = 1'b1;
        state_d = S_PRESENT;
`endif
      end

      S_PRESENT: begin
        if (inst_ready) begin
          valid_d = 1'b0;
          if (jump_en && jump_in_range) begin
            pc_d    = jump_addr;
            state_d = S_ADDR;
          end else if (jump_en) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else if (pc_q == LAST_PC) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_ADDR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ROM_ADDRESS = pc_q;
  assign INST        = inst_q;
  assign inst_valid  = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Scoreboard bench for inst_fetch_seq: a depth-32 instance checked through an expected-word queue,
// plus a depth-20 instance for out-of-range and last-address jumps.
module tb_inst_fetch_seq;

  logic       clk;
  logic       reset;

  // depth-32 instance
  logic       start, inst_ready, jump_en;
  logic [4:0] jump_addr, rom_addr;
  logic [0:8] rom_data;
  logic [8:0] inst;
  logic       inst_valid, busy, done, err;

  // depth-20 instance
  logic       start20, inst_ready20, jump_en20;
  logic [4:0] jump_addr20, rom_addr20;
  logic [0:8] rom_data20;
  logic [8:0] inst20;
  logic       inst_valid20, busy20, done20, err20;

  logic [8:0] rom [32];
  logic [8:0] exp_q [$];

  int vectors    = 0;
  int miscompares = 0;

  inst_fetch_seq #(.width(9), .depth(32), .addrBits(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ROM_ADDRESS(rom_addr), .ROM_DATAIN(rom_data), .INST(inst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .busy(busy), .done(done), .err(err)
  );

  inst_fetch_seq #(.width(9), .depth(20), .addrBits(5)) dut20 (
    .clk(clk), .reset(reset), .start(start20),
    .ROM_ADDRESS(rom_addr20), .ROM_DATAIN(rom_data20), .INST(inst20),
    .inst_valid(inst_valid20), .inst_ready(inst_ready20),
    .jump_en(jump_en20), .jump_addr(jump_addr20),
    .busy(busy20), .done(done20), .err(err20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM models; the [8:0] word is copied positionally onto the [0:8] bus.
  always @(posedge clk) begin
    rom_data   <= rom[rom_addr];
    rom_data20 <= rom[rom_addr20];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word per handshake of the depth-32 instance.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) check("sb_queue_size", 32'(exp_q.size()), 32'd1);
      else check("sb_inst", {23'd0, inst}, {23'd0, exp_q.pop_front()});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start20 = 1'b1; else start = 1'b1;
    tick;
    start20 = 1'b0;
    start   = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(9'(i));
  endtask

  task automatic wait_word(input bit sel, input logic [8:0] w);
    int n;
    for (n = 0; n < 300; n++) begin
      tick;
      if (sel ? (inst_valid20 && inst20 == w) : (inst_valid && inst == w)) break;
    end
    if (n == 300) check("wait_word_timeout", 32'(w), 32'h1FF);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rom[i] = 9'(i);
    reset = 1'b1;
    start = 1'b0; inst_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    start20 = 1'b0; inst_ready20 = 1'b0; jump_en20 = 1'b0; jump_addr20 = '0;
    tick; tick;
    reset = 1'b0;

    // Reset state
    check("rst_inst", {23'd0, inst}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_addr", {27'd0, rom_addr}, 32'd0);

    // Full program, ready tied high; a stray start at cycle 50 must be ignored
    push_range(0, 31);
    inst_ready = 1'b1;
    pulse_start(1'b0);
    for (n = 1; n <= 300; n++) begin
      start = (n == 50);
      tick;
      if (n == 1) check("lat_valid_low", {31'd0, inst_valid}, 32'd0);
      if (n == 2) check("lat_valid_high", {31'd0, inst_valid}, 32'd1);
      if (done) break;
    end
    start = 1'b0;
    check("prog_cycles", 32'(n), 32'd96);
    check("prog_done_err", {30'd0, done, err}, 32'b10);
    check("prog_busy", {31'd0, busy}, 32'd0);
    check("prog_addr", {27'd0, rom_addr}, 32'd31);

    // Stall on word 4 (jump_en asserted without handshake), jump 6->2, then jump 10->31
    push_range(0, 6);
    push_range(2, 10);
    push_range(31, 31);
    pulse_start(1'b0);
    check("restart_clears_done", {31'd0, done}, 32'd0);
    wait_word(1'b0, 9'd4);
    inst_ready = 1'b0;
    jump_en = 1'b1;
    jump_addr = 5'd1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("stall_inst", {23'd0, inst}, 32'd4);
      check("stall_addr", {27'd0, rom_addr}, 32'd4);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
    end
    inst_ready = 1'b1;
    jump_en = 1'b0;
    tick;
    check("resume_valid_c1", {31'd0, inst_valid}, 32'd0);
    tick;
    check("resume_valid_c2", {31'd0, inst_valid}, 32'd0);
    tick;
    check("resume_valid_c3", {31'd0, inst_valid}, 32'd1);
    check("resume_inst", {23'd0, inst}, 32'd5);
    wait_word(1'b0, 9'd6);
    jump_en = 1'b1;
    jump_addr = 5'd2;
    tick;
    jump_en = 1'b0;
    wait_word(1'b0, 9'd10);
    jump_en = 1'b1;
    jump_addr = 5'd31;
    tick;
    jump_en = 1'b0;
    wait_word(1'b0, 9'd31);
    tick;
    check("jump31_done_err", {30'd0, done, err}, 32'b10);
    check("jump31_addr", {27'd0, rom_addr}, 32'd31);

    // depth=20: out-of-range jump, restart, then jump to the last address
    inst_ready20 = 1'b1;
    pulse_start(1'b1);
    wait_word(1'b1, 9'd3);
    jump_en20 = 1'b1;
    jump_addr20 = 5'd25;
    tick;
    jump_en20 = 1'b0;
    check("oor_err_done_busy", {29'd0, err20, done20, busy20}, 32'b110);
    check("oor_valid", {31'd0, inst_valid20}, 32'd0);
    check("oor_addr_held", {27'd0, rom_addr20}, 32'd3);
    pulse_start(1'b1);
    check("oor_restart_flags", {29'd0, err20, done20, busy20}, 32'b001);
    tick; tick;
    check("oor_restart_inst", {22'd0, inst_valid20, inst20}, {22'd0, 1'b1, 9'd0});
    jump_en20 = 1'b1;
    jump_addr20 = 5'd19;
    tick;
    jump_en20 = 1'b0;
    tick; tick;
    check("last20_inst", {22'd0, inst_valid20, inst20}, {22'd0, 1'b1, 9'd19});
    tick;
    check("last20_done_err", {30'd0, done20, err20}, 32'b10);
    check("last20_addr", {27'd0, rom_addr20}, 32'd19);

    // Reset while in CAP on word 10
    push_range(0, 9);
    pulse_start(1'b0);
    wait_word(1'b0, 9'd9);
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrst_addr", {27'd0, rom_addr}, 32'd0);
    check("midrst_flags", {29'd0, busy, done, err}, 32'd0);
    check("midrst_inst", {23'd0, inst}, 32'd0);
    tick; tick; tick;
    check("midrst_stays_idle", {30'd0, inst_valid, busy}, 32'd0);

`ifdef INST_FETCH_HALT_DETECT_EN
    rom[3] = 9'h1FF;
    push_range(0, 2);
    pulse_start(1'b0);
    for (n = 0; n < 100; n++) begin
      tick;
      if (done) break;
    end
    check("halt_done_err", {30'd0, done, err}, 32'b10);
    check("halt_valid", {31'd0, inst_valid}, 32'd0);
    check("halt_inst_held", {23'd0, inst}, 32'd2);
    rom[3] = 9'd3;
`endif

    tick;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
